serial_rb_writer: RTL and testbench

Parametrised serial-to-register-bank loader: it deserialises address/data frames from a one-bit serial link gated by an active-low enable, writes each valid frame into a register bank through a single-cycle write strobe, and raises a sticky done flag once a programmed number of frames has been written. It is the generalised successor of the fixed 3-bit-address/18-bit-data receiver. It adds configurable widths, frame count and optional parity, plus length/parity error detection.

---
 rtl/serial_rb_writer.sv | 121 ++++++++++++
 tb/tb_serial_rb_writer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_rb_writer.sv
// serial_rb_writer: deserialises address/data frames from a gated serial link and writes them into a register bank.
module serial_rb_writer #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 18,
  parameter int NUM_PKT   = 8,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              rb_rw,
  output logic [ADDR_W-1:0] rb_a,
  output logic [DATA_W-1:0] rb_d,
  output logic              done,
  output logic              frame_err,
  output logic [9:0]        pkt_cnt
);
  localparam int FRAME_W = ADDR_W + DATA_W + PARITY_EN;
  localparam int CW = $clog2(FRAME_W + 2);
  localparam logic [CW-1:0] FW = CW'(FRAME_W);
  localparam logic [CW-1:0] FW1 = CW'(FRAME_W + 1);
  localparam logic [9:0] NP = 10'(NUM_PKT);
  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;
  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovr_q, ovr_d;
  logic                rb_rw_q, rb_rw_d;
  logic [ADDR_W-1:0]   rb_a_q, rb_a_d;
  logic [DATA_W-1:0]   rb_d_q, rb_d_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [9:0]          pkt_cnt_q, pkt_cnt_d;
  logic                good;
  logic [9:0]          pkt_inc;
  logic [FRAME_W-1:0]  sr_shift;
  assign sr_shift = {sr_q[FRAME_W-2:0], sd};
  assign pkt_inc = pkt_cnt_q + 10'd1;
  // parity is even over the whole frame, so a good frame XORs to zero
  assign good = (cnt_q == FW) && !ovr_q && (PARITY_EN == 0 || !(^sr_q));
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    rb_rw_d   = 1'b1;
    rb_a_d    = rb_a_q;
    rb_d_d    = rb_d_q;
    done_d    = done_q;
    err_d     = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      IDLE: if (!sen) begin
        sr_d    = sr_shift;
        cnt_d   = CW'(1);
        ovr_d   = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: if (!sen) begin
        ovr_d = ovr_q | (cnt_q >= FW);
        cnt_d = (cnt_q >= FW) ? FW1 : cnt_q + CW'(1);
        sr_d  = (cnt_q >= FW) ? sr_q : sr_shift;
      end else begin
        cnt_d   = '0;
        ovr_d   = 1'b0;
        state_d = good ? WRITE : IDLE;
        err_d   = !good;
        rb_rw_d = !good;
        rb_a_d  = good ? sr_q[FRAME_W-1 -: ADDR_W] : rb_a_q;
        rb_d_d  = good ? sr_q[FRAME_W-1-ADDR_W -: DATA_W] : rb_d_q;
      end
      WRITE: begin
        pkt_cnt_d = pkt_inc;
        if (pkt_inc == NP) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (!sen) begin
          sr_d    = sr_shift;
          cnt_d   = CW'(1);
          ovr_d   = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      rb_rw_q   <= 1'b1;
      rb_a_q    <= '0;
      rb_d_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      rb_rw_q   <= rb_rw_d;
      rb_a_q    <= rb_a_d;
      rb_d_q    <= rb_d_d;
      done_q    <= done_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
  assign rb_rw     = rb_rw_q;
  assign rb_a      = rb_a_q;
  assign rb_d      = rb_d_q;
  assign done      = done_q;
  assign frame_err = err_q;
  assign pkt_cnt   = pkt_cnt_q;
endmodule

// File: tb/tb_serial_rb_writer.sv
// tb_serial_rb_writer: directed table-driven bench for the default and parity-enabled configurations.
module tb_serial_rb_writer;
  logic clk = 1'b0;
  logic rst, sen, sd, sen2, sd2;
  logic rb_rw, done, frame_err;
  logic [2:0] rb_a;
  logic [17:0] rb_d;
  logic [9:0] pkt_cnt;
  logic rb_rw2, done2, err2;
  logic [3:0] rb_a2;
  logic [7:0] rb_d2;
  logic [9:0] cnt2;
  int checks = 0, errors = 0, nw = 0, ne = 0;
  typedef struct {
    logic [22:0] frame;
    int          nbits;
    logic        b2b;
    logic        wr;
    logic [2:0]  a;
    logic [17:0] d;
    logic [9:0]  cnt;
    logic        err;
    logic        dn;
    int          nw;
    int          ne;
  } vec_t;
  vec_t v[14];
  serial_rb_writer dut (
    .clk(clk), .rst(rst), .sen(sen), .sd(sd), .rb_rw(rb_rw), .rb_a(rb_a), .rb_d(rb_d),
    .done(done), .frame_err(frame_err), .pkt_cnt(pkt_cnt)
  );
  serial_rb_writer #(.ADDR_W(4), .DATA_W(8), .NUM_PKT(8), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .sen(sen2), .sd(sd2), .rb_rw(rb_rw2), .rb_a(rb_a2), .rb_d(rb_d2),
    .done(done2), .frame_err(err2), .pkt_cnt(cnt2)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst) begin
    if (!rb_rw) nw++;
    if (frame_err) ne++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask
  task automatic run(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      for (int b = 0; b < v[k].nbits; b++) begin
        sen = 1'b0;
        sd = v[k].frame[v[k].nbits-1-b];
        @(negedge clk);
      end
      sen = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_rw_strobe", k), rb_rw, !v[k].wr);
      chk($sformatf("v%0d_err_pulse", k), frame_err, v[k].err);
      if (v[k].wr) begin
        chk($sformatf("v%0d_wr_a", k), rb_a, v[k].a);
        chk($sformatf("v%0d_wr_d", k), rb_d, v[k].d);
      end
      if (!v[k].b2b) begin
        @(negedge clk);
        chk($sformatf("v%0d_rw_idle", k), rb_rw, 1);
        chk($sformatf("v%0d_err_clear", k), frame_err, 0);
        chk($sformatf("v%0d_a", k), rb_a, v[k].a);
        chk($sformatf("v%0d_d", k), rb_d, v[k].d);
        chk($sformatf("v%0d_cnt", k), pkt_cnt, v[k].cnt);
        chk($sformatf("v%0d_done", k), done, v[k].dn);
        chk($sformatf("v%0d_nwrites", k), nw, v[k].nw);
        chk($sformatf("v%0d_nerrs", k), ne, v[k].ne);
      end
    end
  endtask
  task automatic send2(input logic [12:0] f, input logic wr, input logic [3:0] a,
                       input logic [7:0] d, input logic [9:0] c);
    for (int b = 12; b >= 0; b--) begin
      sen2 = 1'b0;
      sd2 = f[b];
      @(negedge clk);
    end
    sen2 = 1'b1;
    @(negedge clk);
    chk("par_rw", rb_rw2, !wr);
    chk("par_err", err2, !wr);
    @(negedge clk);
    chk("par_a", rb_a2, a);
    chk("par_d", rb_d2, d);
    chk("par_cnt", cnt2, c);
  endtask
  initial begin
    rst = 1'b1; sen = 1'b1; sd = 1'b0; sen2 = 1'b1; sd2 = 1'b0;
    v[0] = '{23'hABCDE, 20, 0, 0, 3'd0, 18'd0, 10'd0, 1, 0, 0, 1};
    v[1] = '{{2'b0, 3'd5, 18'h12345}, 21, 0, 1, 3'd5, 18'h12345, 10'd1, 0, 0, 1, 1};
    v[2] = '{23'h7FFFFF, 23, 0, 0, 3'd5, 18'h12345, 10'd1, 1, 0, 1, 2};
    v[3] = '{{2'b0, 3'd6, 18'h2AAAA}, 21, 0, 1, 3'd6, 18'h2AAAA, 10'd2, 0, 0, 2, 2};
    for (int i = 0; i < 8; i++)
      v[4+i] = '{{2'b0, 3'(i), 18'(18'h30000 + i)}, 21, i == 0, 1, 3'(i), 18'(18'h30000 + i),
                 10'(i + 1), 0, i == 7, 3 + i, 2};
    v[12] = '{{2'b0, 3'd1, 18'h00001}, 21, 0, 0, 3'd7, 18'h30007, 10'd8, 0, 1, 10, 2};
    v[13] = '{23'h00FFF, 20, 0, 0, 3'd7, 18'h30007, 10'd8, 0, 1, 10, 2};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rw", rb_rw, 1);
    chk("rst_a", rb_a, 0);
    chk("rst_d", rb_d, 0);
    chk("rst_done", done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cnt", pkt_cnt, 0);
    chk("rst_rw_par", rb_rw2, 1);
    run(0, 3);
    for (int b = 0; b < 10; b++) begin
      sen = 1'b0;
      sd = b[0];
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_rw", rb_rw, 1);
    chk("midrst_a", rb_a, 0);
    chk("midrst_d", rb_d, 0);
    chk("midrst_cnt", pkt_cnt, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    sen = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_nwrites", nw, 2);
    chk("postrst_cnt", pkt_cnt, 0);
    chk("postrst_rw", rb_rw, 1);
    run(4, 13);
    send2({4'hA, 8'h5C, 1'b0}, 1, 4'hA, 8'h5C, 10'd1);
    send2({4'hA, 8'h5C, 1'b1}, 0, 4'hA, 8'h5C, 10'd1);
    send2({4'h3, 8'h01, 1'b1}, 1, 4'h3, 8'h01, 10'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
